// File: rtl/rv32_pkg.sv
// Shared types for the RV32 fetch stage: FSM states, IF/ID entry layout and the
// canonical NOP encoding presented when IF/ID holds no instruction.
package rv32_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
    } if_id_t;

    localparam if_id_t IF_ID_EMPTY = '{valid: 1'b0, pc: 32'h0, instr: NOP_INSTR};

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry IF/ID skid buffer: catches a fetch response that arrives while
// decode is stalled on a live instruction. Clear (flush) beats push and pop.
module fetch_skid_buf
    import rv32_pkg::*;
(
    input  logic   clk_i,
    input  logic   rst_ni,
    input  logic   push,
    input  logic   pop,
    input  logic   clear,
    input  if_id_t din,
    output if_id_t dout,
    output logic   full
);

    if_id_t data_p1;
    logic   full_p1;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            full_p1 <= 1'b0;
        end else if (clear) begin
            full_p1 <= 1'b0;
        end else if (push) begin
            full_p1 <= 1'b1;
        end else if (pop) begin
            full_p1 <= 1'b0;
        end
    end

    // Payload needs no reset: it is only observed while full is set.
    always_ff @(posedge clk_i) begin
        if (push) begin
            data_p1 <= din;
        end
    end

    assign dout = data_p1;
    assign full = full_p1;

endmodule

// File: rtl/fetch_stage.sv
// RV32 instruction-fetch stage with IF/ID register, load-use stall and EX redirect.
// Define RV32_FETCH_PERF_EN to add saturating fetch/stall/flush counters.
module fetch_stage
    import rv32_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            stall_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    output logic            if_id_valid_o,
    output logic [XLEN-1:0] if_id_pc_o,
    output logic [XLEN-1:0] if_id_instr_o
`ifdef RV32_FETCH_PERF_EN
    ,
    output logic [31:0]     perf_fetch_cnt_o,
    output logic [31:0]     perf_stall_cnt_o,
    output logic [31:0]     perf_flush_cnt_o
`endif
);

    fetch_state_e    state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] req_pc;
    logic [XLEN-1:0] addr;
    logic            kill;
    if_id_t          if_id_p1;
    if_id_t          skid_dout;
    if_id_t          rsp_entry;
    logic            skid_full;
    logic [XLEN-1:0] redirect_tgt;
    logic [XLEN-1:0] pc_nxt;
    logic            rsp;
    logic            rsp_live;
    logic            to_if_id;
    logic            to_skid;

    assign redirect_tgt = redirect_pc_i & ~XLEN'(3);
    assign rsp          = (state == WAIT) && imem_rvalid_i;
    assign rsp_live     = rsp && !kill && !redirect_i;
    assign to_if_id     = rsp_live && (!if_id_p1.valid || !stall_i);
    assign to_skid      = rsp_live && !to_if_id;
    assign rsp_entry    = '{valid: 1'b1, pc: req_pc, instr: imem_rdata_i};
    assign pc_nxt       = redirect_i ? redirect_tgt :
                          rsp_live   ? req_pc + XLEN'(4) : pc;

    fetch_skid_buf u_skid (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push   (to_skid),
        .pop    (skid_full && !stall_i),
        .clear  (redirect_i),
        .din    (rsp_entry),
        .dout   (skid_dout),
        .full   (skid_full)
    );

    // addr is only reloaded on entry to REQ, so it stays put until granted.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state <= IDLE;
            pc    <= RESET_PC;
            addr  <= RESET_PC;
            kill  <= 1'b0;
        end else begin
            pc <= pc_nxt;
            unique case (state)
                IDLE: begin
                    state <= REQ;
                    addr  <= pc_nxt;
                end
                REQ: begin
                    if (redirect_i) kill <= 1'b1;
                    if (imem_gnt_i) state <= WAIT;
                end
                WAIT: begin
                    if (rsp) begin
                        kill  <= 1'b0;
                        state <= to_skid ? HOLD : REQ;
                        addr  <= pc_nxt;
                    end else if (redirect_i) begin
                        kill <= 1'b1;
                    end
                end
                HOLD: begin
                    if (redirect_i || !stall_i) begin
                        state <= REQ;
                        addr  <= pc_nxt;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (state == REQ && imem_gnt_i) begin
            req_pc <= pc;
        end
    end

    // IF/ID stage boundary
    always_ff @(posedge clk_i) begin
        if (!rst_ni || redirect_i) begin
            if_id_p1 <= IF_ID_EMPTY;
        end else if (to_if_id) begin
            if_id_p1 <= rsp_entry;
        end else if (!stall_i) begin
            if_id_p1 <= skid_full ? skid_dout : IF_ID_EMPTY;
        end
    end

    assign imem_req_o    = (state == REQ);
    assign imem_addr_o   = addr;
    assign if_id_valid_o = if_id_p1.valid;
    assign if_id_pc_o    = if_id_p1.pc;
    assign if_id_instr_o = if_id_p1.instr;

`ifdef RV32_FETCH_PERF_EN
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            fetch_cnt <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (rsp_live)                    fetch_cnt <= sat_inc(fetch_cnt);
            if (stall_i && if_id_p1.valid)   stall_cnt <= sat_inc(stall_cnt);
            if (redirect_i)                  flush_cnt <= sat_inc(flush_cnt);
        end
    end

    assign perf_fetch_cnt_o = fetch_cnt;
    assign perf_stall_cnt_o = stall_cnt;
    assign perf_flush_cnt_o = flush_cnt;
`endif

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch (IF) stage and IF/ID pipeline register, directly upstream of the decode-stage load-use stall logic.
- Owns the PC and issues word requests on a req/gnt/rvalid instruction-memory port.
- Presents {pc, instr, valid} to ID.
- Holds IF/ID when stall_i is high; flushes on a branch/jump redirect from EX.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.
XLEN, 32, data/address width.

Ports:
clk_i  in  1  clock; all state updates on the rising edge
rst_ni  in  1  synchronous, active-low reset
stall_i  in  1  load-use stall from the decode hazard logic; hold IF/ID
redirect_i  in  1  taken branch/jump from EX; flush and refetch
redirect_pc_i  in  XLEN  redirect target; bits [1:0] ignored (treated as 0)
imem_req_o  out  1  fetch request valid
imem_addr_o  out  XLEN  fetch word address
imem_gnt_i  in  1  request accepted this cycle
imem_rvalid_i  in  1  response data valid (≥1 cycle after gnt)
imem_rdata_i  in  XLEN  instruction word
if_id_valid_o  out  1  IF/ID holds a live instruction
if_id_pc_o  out  XLEN  PC of the IF/ID instruction
if_id_instr_o  out  XLEN  instruction; NOP (32'h0000_0013) when invalid

Behaviour:
- Reset (rst_ni=0 at the clock edge):
  - pc=RESET_PC; state=IDLE; kill=0; skid empty.
  - if_id_valid_o=0, if_id_pc_o=0, if_id_instr_o=NOP.
  - imem_req_o=0, imem_addr_o=RESET_PC.
- Reset mid-transaction: any rvalid arriving while in IDLE is ignored.
- FSM states:
  - IDLE: imem_req_o=0. Go to REQ on the next edge.
  - REQ: imem_req_o=1, imem_addr_o=pc. On gnt, latch req_pc=pc and go to WAIT.
  - WAIT: imem_req_o=0. On rvalid, go to REQ, or to HOLD if the response had to be buffered.
  - HOLD: skid full; no requests. When the skid drains into IF/ID, go to REQ.
- Request stability: imem_addr_o must not change while imem_req_o=1 and gnt=0, including across a redirect.
- One outstanding request maximum. Minimum 2 cycles per fetch with a 0-wait memory.
- Response (WAIT, rvalid=1, kill=0), with instruction {req_pc, rdata}:
  - If IF/ID is empty or stall_i=0: load it into IF/ID (valid=1) and set pc=req_pc+4 (wrap at 2^32).
  - Otherwise: write it to the 1-entry skid buffer.
- Stall:
  - stall_i=1 holds if_id_* unchanged.
  - When stall_i=0 and the skid is full, the skid moves into IF/ID the same edge.
  - When stall_i=0, the skid is empty and no response arrives, IF/ID becomes invalid (bubble).
- Redirect (priority over everything except reset; wins over a simultaneous stall_i):
  - pc=redirect_pc_i & ~3.
  - IF/ID invalidated (instr=NOP); skid cleared.
  - If a request is outstanding (WAIT, or REQ with gnt this cycle), set kill=1.
  - If in REQ without gnt, keep requesting the old address and set kill.
  - A response with kill=1 is discarded, kill clears, then go to REQ with the redirect pc.
  - From HOLD, go to REQ.
- Redirect in the same cycle as rvalid (kill=0): the response is discarded, with no kill set.

Optional Feature:
RV32_FETCH_PERF_EN
- Defined:
  - Adds 32-bit outputs perf_fetch_cnt_o (accepted non-killed responses), perf_stall_cnt_o (cycles with stall_i=1 and if_id_valid_o=1) and perf_flush_cnt_o (redirect cycles).
  - All three are saturating and reset to 0.
- Undefined: these ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- rv32_pkg:
  - fetch_state_e {IDLE, REQ, WAIT, HOLD}.
  - NOP_INSTR = 32'h0000_0013.
  - if_id_t struct {valid, pc, instr}.
- Sub-module fetch_skid_buf: 1-entry if_id_t buffer with push/pop/clear and full flag.

Test Plan:
1. Reset release, 0-wait memory returning rdata=addr^32'hA5A5_0000 → IF/ID sequence pc 0x0,0x4,0x8, each valid, one instruction per 2 cycles.
2. stall_i high for 5 cycles while a response arrives → IF/ID holds pc 0x4; skid takes 0x8; HOLD (no req); on release 0x8 appears next edge, then fetch resumes at 0xC.
3. redirect_i with redirect_pc_i=0x1002 while in WAIT → IF/ID invalid/NOP next edge; in-flight response dropped; next request addr 0x1000.
4. Redirect in REQ with gnt=0 for 3 cycles → imem_addr_o stays at the old pc until gnt; response dropped; then request at the redirect target.
5. stall_i and redirect_i together → flush wins: if_id_valid_o=0, skid cleared.
6. rst_ni low during WAIT, then rvalid → response ignored; fetch restarts at RESET_PC.
